// File: rtl/win_pkg.sv
// win_pkg: shared gearbox state encoding, pointer wrap helper and datapath defaults
package win_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_DEF   = 3;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        CLEAR
    } state_t;

    // inc never exceeds depth and ptr is always below depth, so one subtraction wraps
    function automatic int ptr_wrap(int ptr, int inc, int depth);
        int s = ptr + inc;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/pix_ring.sv
// pix_ring: circular pixel array, IN_PIX-wide write and WIN-wide read at arbitrary pixel pointers
module pix_ring
    import win_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int IN_PIX    = 8,
    parameter int WIN       = WIN_DEF,
    parameter int DEPTH_PIX = 16,
    parameter int PTR_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic [IN_PIX*PIX_W-1:0] wr_data,
    input  logic [PTR_W-1:0]        rd_ptr,
    output logic [WIN*PIX_W-1:0]    rd_data
);

    logic [PIX_W-1:0] mem [DEPTH_PIX];

    // each incoming pixel lands in its own slot, wrapping pixel-by-pixel past the array end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_PIX; i++) mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < IN_PIX; i++)
                mem[PTR_W'(ptr_wrap(32'(wr_ptr), i, DEPTH_PIX))] <= wr_data[i*PIX_W +: PIX_W];
        end
    end

    // window gathered from consecutive wrapped slots, oldest pixel at the LSB
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < WIN; j++)
            rd_data[j*PIX_W +: PIX_W] = mem[PTR_W'(ptr_wrap(32'(rd_ptr), j, DEPTH_PIX))];
    end

endmodule

// File: rtl/window_gearbox.sv
// window_gearbox: packs line-buffer words into overlapping WIN-pixel windows advanced by STRIDE
module window_gearbox
    import win_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int IN_PIX    = 8,
    parameter int WIN       = WIN_DEF,
    parameter int STRIDE    = 1,
    parameter int DEPTH_PIX = 16,
    parameter int CNT_W     = $clog2(DEPTH_PIX + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [IN_PIX*PIX_W-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [WIN*PIX_W-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [CNT_W-1:0]        count
);

    localparam int PTR_W = (DEPTH_PIX > 1) ? $clog2(DEPTH_PIX) : 1;

    typedef logic [CNT_W:0] cntx_t;

    state_t           state;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             push, pop;
    cntx_t            cnt_x, cnt_next;

    if (STRIDE < 1 || STRIDE > WIN) begin : g_bad_stride
        $error("window_gearbox: STRIDE must lie in 1..WIN");
    end
    if (DEPTH_PIX < IN_PIX + WIN - 1) begin : g_bad_depth
        $error("window_gearbox: DEPTH_PIX must be at least IN_PIX+WIN-1");
    end

    // handshakes and row-end flag from registered state; extra count bit keeps count-STRIDE from wrapping
    always_comb begin
        cnt_x    = {1'b0, count};
        s_ready  = (state == FILL) && (cnt_x <= cntx_t'(DEPTH_PIX - IN_PIX));
        m_valid  = (state != CLEAR) && (cnt_x >= cntx_t'(WIN));
        m_last   = (state == DRAIN) && m_valid && (cnt_x - cntx_t'(STRIDE) < cntx_t'(WIN));
        push     = s_valid && s_ready;
        pop      = m_valid && m_ready;
        cnt_next = cnt_x + (push ? cntx_t'(IN_PIX) : '0) - (pop ? cntx_t'(STRIDE) : '0);
    end

    // row FSM and pointers; CLEAR discards row leftovers exactly like a flush
    always_ff @(posedge clk) begin
        if (!reset_n || flush || state == CLEAR) begin
            state  <= FILL;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= cnt_next[CNT_W-1:0];
            if (push) wr_ptr <= PTR_W'(ptr_wrap(32'(wr_ptr), IN_PIX, DEPTH_PIX));
            if (pop) rd_ptr <= PTR_W'(ptr_wrap(32'(rd_ptr), STRIDE, DEPTH_PIX));
            if (state == FILL && push && s_last)
                state <= DRAIN;
            else if (state == DRAIN && ((pop && m_last) || cnt_x < cntx_t'(WIN)))
                state <= CLEAR;
        end
    end

    pix_ring #(
        .PIX_W     (PIX_W),
        .IN_PIX    (IN_PIX),
        .WIN       (WIN),
        .DEPTH_PIX (DEPTH_PIX),
        .PTR_W     (PTR_W)
    ) u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (s_data),
        .rd_ptr  (rd_ptr),
        .rd_data (m_data)
    );

endmodule

// File: tb/tb_window_gearbox.sv
// tb_window_gearbox: directed table, corner sequences and randomized queue-model check of window_gearbox
module tb_window_gearbox;

    localparam int IP = 8;
    localparam int WN = 3;
    localparam int DP = 16;
    localparam int ST = 1;

    logic        clk = 0, reset_n = 0, flush = 0, s_valid = 0, s_last = 0, m_ready = 0;
    logic [63:0] s_data = '0;
    logic        s_ready, m_valid, m_last, s_ready2, m_valid2, m_last2;
    logic [23:0] m_data, m_data2;
    logic [4:0]  count, count2;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    window_gearbox dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .count(count)
    );

    window_gearbox #(.STRIDE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready2), .s_last(s_last), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(m_ready), .m_last(m_last2), .count(count2)
    );

    typedef struct {
        logic        sv, sl, mr;
        logic [63:0] d;
        logic        ev, el, er, cd;
        logic [23:0] ed;
        int          ec;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic l, logic [63:0] d, logic mr);
        s_valid = v;
        s_last  = l;
        s_data  = d;
        m_ready = mr;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0);
        flush   = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic expect_out(string t, logic ev, logic [23:0] ed, logic el, logic er, int ec, logic cd);
        chk({t, " m_valid"}, m_valid, ev);
        chk({t, " m_last"}, m_last, el);
        chk({t, " s_ready"}, s_ready, er);
        chk({t, " count"}, count, ec);
        if (cd) chk({t, " m_data"}, m_data, ed);
    endtask

    function automatic logic [63:0] word(int base);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(base + i);
        return w;
    endfunction

    function automatic logic [23:0] win(int s);
        return {8'(s + 2), 8'(s + 1), 8'(s)};
    endfunction

    // reference model: a plain pixel queue plus a row phase (0 accepting, 1 row closed, 2 discard)
    logic [7:0] q[$];
    int         phase;

    initial begin
        int n;
        logic mv, ml, sr, push, pop;
        // row of two words with continuous consumption, preceded by the single-word latency check
        tbl[0] = '{sv:1, sl:0, mr:0, d:word(0), ev:1, el:0, er:1, cd:1, ed:win(0), ec:8};
        for (int k = 1; k <= 13; k++)
            tbl[k] = '{sv:(k == 1), sl:(k == 1), mr:1, d:word(8), ev:1, el:(k == 13), er:0, cd:1,
                       ed:win(k), ec:16 - k};
        tbl[14] = '{sv:0, sl:0, mr:1, d:'0, ev:0, el:0, er:0, cd:0, ed:'0, ec:2};
        tbl[15] = '{sv:0, sl:0, mr:0, d:'0, ev:0, el:0, er:1, cd:0, ed:'0, ec:0};

        do_reset();
        expect_out("reset", 0, 24'h0, 0, 1, 0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].sv, tbl[i].sl, tbl[i].d, tbl[i].mr);
            tick();
            expect_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].er, tbl[i].ec, tbl[i].cd);
        end

        // backpressure: full buffer holds off a third word; s_ready returns only at count 8
        do_reset();
        drive(1, 0, word(0), 0);
        tick();
        chk("bp count1", count, 8);
        drive(1, 0, word(8), 0);
        tick();
        chk("bp count2", count, 16);
        chk("bp s_ready full", s_ready, 0);
        drive(1, 0, word(16), 0);
        tick();
        chk("bp held count", count, 16);
        drive(0, 0, '0, 1);
        for (int k = 15; k >= 8; k--) begin
            tick();
            chk($sformatf("bp count%0d", k), count, k);
            chk($sformatf("bp s_ready%0d", k), s_ready, k <= 8);
            if (k == 15) chk("bp data", m_data, win(1));
        end

        // stride 2: three windows, last flagged, leftover pixel discarded
        do_reset();
        drive(1, 1, word(0), 1);
        tick();
        drive(0, 0, '0, 1);
        chk("s2 data0", m_data2, win(0));
        chk("s2 count0", count2, 8);
        chk("s2 last0", m_last2, 0);
        tick();
        chk("s2 data1", m_data2, win(2));
        chk("s2 count1", count2, 6);
        chk("s2 last1", m_last2, 0);
        tick();
        chk("s2 data2", m_data2, win(4));
        chk("s2 count2", count2, 4);
        chk("s2 last2", m_last2, 1);
        tick();
        chk("s2 clear valid", m_valid2, 0);
        chk("s2 clear s_ready", s_ready2, 0);
        tick();
        chk("s2 done count", count2, 0);
        chk("s2 done s_ready", s_ready2, 1);

        // wrap-around: windows stay contiguous across the array end
        do_reset();
        drive(1, 0, word(0), 0);
        tick();
        n = 8;
        for (int k = 0; k < 16; k++) begin
            drive((k == 0 || k == 8), 0, word(k == 0 ? 8 : 16), 1);
            tick();
            n = n + ((k == 0 || k == 8) ? 8 : 0) - 1;
            chk($sformatf("wrap data%0d", k + 1), m_data, win(k + 1));
            chk($sformatf("wrap count%0d", k + 1), count, n);
        end

        // flush mid-row at count 11 drops everything without m_last
        do_reset();
        drive(1, 0, word(0), 0);
        tick();
        drive(1, 1, word(8), 0);
        tick();
        drive(0, 0, '0, 1);
        repeat (5) tick();
        chk("fl pre count", count, 11);
        flush = 1;
        tick();
        flush = 0;
        drive(0, 0, '0, 0);
        expect_out("flush", 0, 24'h0, 0, 1, 0, 0);
        drive(1, 0, word(32), 0);
        tick();
        drive(0, 0, '0, 0);
        expect_out("post flush", 1, win(32), 0, 1, 8, 1);

        // reset mid-row also clears the pixel store
        do_reset();
        drive(1, 1, word(0), 1);
        tick();
        drive(0, 0, '0, 1);
        tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        drive(0, 0, '0, 0);
        expect_out("mid reset", 0, 24'h0, 0, 1, 0, 1);

        // randomized traffic against the queue model
        do_reset();
        q.delete();
        phase = 0;
        for (int c = 0; c < 3000; c++) begin
            int n0;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            n0 = q.size();
            sr = (phase == 0) && (n0 <= DP - IP);
            mv = (phase != 2) && (n0 >= WN);
            ml = (phase == 1) && mv && (n0 - ST < WN);
            chk("rnd s_ready", s_ready, sr);
            chk("rnd m_valid", m_valid, mv);
            chk("rnd m_last", m_last, ml);
            chk("rnd count", count, n0);
            if (mv) chk("rnd m_data", m_data, {q[2], q[1], q[0]});
            push = s_valid && sr;
            pop  = mv && m_ready;
            tick();
            if (flush || phase == 2) begin
                q.delete();
                phase = 0;
            end else begin
                if (pop) repeat (ST) void'(q.pop_front());
                if (push) for (int i = 0; i < IP; i++) q.push_back(s_data[i*8 +: 8]);
                if (phase == 0 && push && s_last) phase = 1;
                else if (phase == 1 && ((pop && ml) || n0 < WN)) phase = 2;
            end
        end
        flush = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
